wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit_pkg.sv | 16 +
 rtl/wb_unit_scoreboard.sv | 60 ++++++
 rtl/wb_unit.sv | 119 +++++++++++
 tb/tb_wb_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback unit.
//   WB_ADDR_WIDTH : default register index width
//   WB_DATA_WIDTH : default result data width
//   src_sel_t     : which result source is accepted in a cycle
package wb_unit_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 5;
  localparam int unsigned WB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EXU,
    SRC_LSU
  } src_sel_t;

endpackage

// File: rtl/wb_unit_scoreboard.sv
// wb_scoreboard: one busy bit per architectural register (bit 0 hardwired 0).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_req/set_idx     request to mark set_idx pending
//   set_ready           set_idx may be marked this cycle (WAW stall otherwise)
//   clr_en/clr_idx      write retiring to clr_idx this cycle
//   q1_idx/q2_idx       query indices
//   q1_busy/q2_busy     pending status of the queried indices
module wb_scoreboard
  import wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_req,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  output logic                  set_ready,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] q1_idx,
  input  logic [ADDR_WIDTH-1:0] q2_idx,
  output logic                  q1_busy,
  output logic                  q2_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             clr_hit;

  // A retiring write to the same index blocks reissue for this cycle, so the
  // clear can never collide with a fresh set.
  assign clr_hit   = clr_en && (clr_idx == set_idx);
  assign set_ready = (set_idx == '0) || (!busy[set_idx] && !clr_hit);

  always_comb begin
    busy_next = busy;
    if (set_req && set_ready) begin
      busy_next[set_idx] = 1'b1;
    end
    if (clr_en) begin
      busy_next[clr_idx] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign q1_busy = busy[q1_idx];
  assign q2_busy = busy[q2_idx];

endmodule

// File: rtl/wb_unit.sv
// wb_unit: arbitrates ALU and load results onto a single registered register
// file write port and tracks outstanding destinations in a scoreboard.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   exu_valid/exu_ready/rd/data    ALU result handshake (loses to LSU)
//   lsu_valid/lsu_ready/rd/data    load result handshake (always ready)
//   iss_valid/iss_ready/iss_rd     issue marking a destination pending
//   rs1/rs2 -> rs1_busy/rs2_busy   source pending status
//   rf_wen/rf_waddr/rf_wdata       registered write port
// Optional (macro WB_BYPASS_EN): rs1_byp/rs2_byp, rs1_bdata/rs2_bdata forward
// the value currently on the write port when it targets a queried source.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef WB_BYPASS_EN
  output logic                  rs1_byp,
  output logic                  rs2_byp,
  output logic [DATA_WIDTH-1:0] rs1_bdata,
  output logic [DATA_WIDTH-1:0] rs2_bdata,
`endif
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  src_sel_t              src;
  logic [ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  q1_busy;
  logic                  q2_busy;

  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;

  always_comb begin
    src      = SRC_NONE;
    acc_rd   = '0;
    acc_data = '0;
    if (lsu_valid) begin
      src      = SRC_LSU;
      acc_rd   = lsu_rd;
      acc_data = lsu_data;
    end else if (exu_valid) begin
      src      = SRC_EXU;
      acc_rd   = exu_rd;
      acc_data = exu_data;
    end
  end

  // rd=0 results are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= (src != SRC_NONE) && (acc_rd != '0);
      if (src != SRC_NONE) begin
        rf_waddr <= acc_rd;
        rf_wdata <= acc_data;
      end
    end
  end

  wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_req  (iss_valid),
    .set_idx  (iss_rd),
    .set_ready(iss_ready),
    .clr_en   (rf_wen),
    .clr_idx  (rf_waddr),
    .q1_idx   (rs1),
    .q2_idx   (rs2),
    .q1_busy  (q1_busy),
    .q2_busy  (q2_busy)
  );

`ifdef WB_BYPASS_EN
  logic hit1;
  logic hit2;

  // rf_wen already implies rf_waddr != 0, so index 0 can never forward.
  assign hit1      = rf_wen && (rf_waddr == rs1);
  assign hit2      = rf_wen && (rf_waddr == rs2);
  assign rs1_byp   = hit1;
  assign rs2_byp   = hit2;
  assign rs1_bdata = hit1 ? rf_wdata : '0;
  assign rs2_bdata = hit2 ? rf_wdata : '0;
  assign rs1_busy  = q1_busy && !hit1;
  assign rs2_busy  = q2_busy && !hit2;
`else
  assign rs1_busy = q1_busy;
  assign rs2_busy = q2_busy;
`endif

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 1 << AW;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          exu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic [AW-1:0] exu_rd = '0, lsu_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [DW-1:0] exu_data = '0, lsu_data = '0;
  logic          exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic          rs1_byp, rs2_byp;
  logic [DW-1:0] rs1_bdata, rs2_bdata;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: set of pending destinations plus the write expected on
  // the port in the current cycle.
  bit          pend[NREG];
  bit          m_wen;
  int unsigned m_waddr;
  int unsigned m_wdata;

  always #5 clk = ~clk;

  wb_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_BYPASS_EN
    .rs1_byp(rs1_byp), .rs2_byp(rs2_byp), .rs1_bdata(rs1_bdata), .rs2_bdata(rs2_bdata),
`endif
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  function automatic bit m_iss_ready();
    if (iss_rd == 0) return 1'b1;
    if (pend[iss_rd]) return 1'b0;
    if (m_wen && m_waddr == iss_rd) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_src_busy(input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (BYP && m_wen && m_waddr == idx) return 1'b0;
    return pend[idx];
  endfunction

  task automatic m_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_wen = 1'b0; m_waddr = 0; m_wdata = 0;
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic m_edge();
    bit          take_iss;
    bit          old_wen;
    int unsigned old_waddr;
    take_iss  = iss_valid && m_iss_ready() && iss_rd != 0;
    old_wen   = m_wen;
    old_waddr = m_waddr;
    if (lsu_valid) begin
      m_wen = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data;
    end else if (exu_valid) begin
      m_wen = (exu_rd != 0); m_waddr = exu_rd; m_wdata = exu_data;
    end else begin
      m_wen = 1'b0;
    end
    if (take_iss) pend[iss_rd] = 1'b1;
    if (old_wen) pend[old_waddr] = 1'b0;
  endtask

  task automatic drive(input bit ev, input int erd, input int unsigned ed,
                       input bit lv, input int lrd, input int unsigned ld,
                       input bit iv, input int ird, input int r1, input int r2);
    exu_valid = ev; exu_rd = AW'(erd); exu_data = ed;
    lsu_valid = lv; lsu_rd = AW'(lrd); lsu_data = ld;
    iss_valid = iv; iss_rd = AW'(ird);
    rs1 = AW'(r1); rs2 = AW'(r2);
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    drive(0, 0, 0, 1, 3, 5, 1, 9, 4, 6);
    #1;
    tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %b want 0", rf_wen); end
    tests++; if (rf_waddr !== '0) begin fails++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
    tests++; if (rf_wdata !== '0) begin fails++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    tests++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_lsu got exu=%b lsu=%b want 0/1", exu_ready, lsu_ready); end
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL reset_iss_ready got %b want 1", iss_ready); end
    tests++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin fails++; $display("FAIL reset_rs_busy got %b%b want 00", rs1_busy, rs2_busy); end
    idle();
    #1;
    tests++; if (exu_ready !== 1'b1) begin fails++; $display("FAIL reset_exu_ready got %b want 1", exu_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL post_reset_wen got %b want 0", rf_wen); end
  endtask

  task automatic test_issue_write();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    #1;
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL iw_iss_ready got %b want 1", iss_ready); end
    tick();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    #1;
    tests++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL iw_busy_before got %b want 1", rs1_busy); end
    tick();
    tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL iw_write got wen=%b addr=%0d data=%h want 1/5/deadbeef", rf_wen, rf_waddr, rf_wdata);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    tests++; if (rs1_busy !== !BYP) begin fails++; $display("FAIL iw_busy_during got %b want %b", rs1_busy, !BYP); end
    tick();
    tests++; if (rs1_busy !== 1'b0 || rf_wen !== 1'b0) begin fails++; $display("FAIL iw_after got busy=%b wen=%b want 0/0", rs1_busy, rf_wen); end
  endtask

  task automatic test_priority();
    drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
    #1;
    tests++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b1) begin fails++; $display("FAIL pri_ready got exu=%b lsu=%b want 0/1", exu_ready, lsu_ready); end
    tick();
    tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      fails++; $display("FAIL pri_lsu_first got wen=%b addr=%0d data=%h want 1/4/22", rf_wen, rf_waddr, rf_wdata);
    end
    drive(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (exu_ready !== 1'b1) begin fails++; $display("FAIL pri_exu_ready got %b want 1", exu_ready); end
    tick();
    tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      fails++; $display("FAIL pri_exu_second got wen=%b addr=%0d data=%h want 1/3/11", rf_wen, rf_waddr, rf_wdata);
    end
    idle();
    tick();
    tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL pri_no_dup got wen=%b want 0", rf_wen); end
  endtask

  task automatic test_waw();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    tick();
    #1;
    tests++; if (iss_ready !== 1'b0 || rs1_busy !== 1'b1) begin fails++; $display("FAIL waw_stall got rdy=%b busy=%b want 0/1", iss_ready, rs1_busy); end
    tick();
    drive(1, 7, 32'h77, 0, 0, 0, 1, 7, 7, 0);
    #1;
    tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL waw_stall2 got %b want 0", iss_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    #1;
    tests++; if (rf_wen !== 1'b1 || iss_ready !== 1'b0) begin fails++; $display("FAIL waw_clear_cycle got wen=%b rdy=%b want 1/0", rf_wen, iss_ready); end
    tick();
    tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL waw_reissue got %b want 1", iss_ready); end
    tick();
    drive(1, 7, 32'h78, 0, 0, 0, 0, 0, 7, 0);
    #1;
    tests++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL waw_reissued_busy got %b want 1", rs1_busy); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_rd0();
    drive(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    #1;
    tests++; if (iss_ready !== 1'b1 || rs1_busy !== 1'b0) begin fails++; $display("FAIL rd0_comb got rdy=%b busy=%b want 1/0", iss_ready, rs1_busy); end
    tick();
    tests++; if (rf_wen !== 1'b0 || rs1_busy !== 1'b0 || iss_ready !== 1'b1) begin
      fails++; $display("FAIL rd0_discard got wen=%b busy=%b rdy=%b want 0/0/1", rf_wen, rs1_busy, iss_ready);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    tick();
    drive(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    tick();
    idle(); rs1 = AW'(9);
    rst_n = 1'b0;
    m_reset();
    #1;
    tests++; if (rf_wen !== 1'b0 || rs1_busy !== 1'b0) begin fails++; $display("FAIL rmid_during got wen=%b busy=%b want 0/0", rf_wen, rs1_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (rf_wen !== 1'b0 || rs1_busy !== 1'b0) begin fails++; $display("FAIL rmid_after got wen=%b busy=%b want 0/0", rf_wen, rs1_busy); end
    drive(1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd2) begin fails++; $display("FAIL rmid_first got wen=%b addr=%0d want 1/2", rf_wen, rf_waddr); end
    idle();
    tick();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    tick();
    drive(1, 6, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(); rs1 = AW'(5); rs2 = AW'(6);
    #1;
    tests++; if (rs2_byp !== 1'b1 || rs2_bdata !== 32'h1234 || rs2_busy !== 1'b0) begin
      fails++; $display("FAIL byp_hit got byp=%b data=%h busy=%b want 1/1234/0", rs2_byp, rs2_bdata, rs2_busy);
    end
    tests++; if (rs1_byp !== 1'b0 || rs1_bdata !== '0) begin fails++; $display("FAIL byp_miss got byp=%b data=%h want 0/0", rs1_byp, rs1_bdata); end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      #1;
      tests++; if (exu_ready !== !lsu_valid || lsu_ready !== 1'b1) begin
        fails++; $display("FAIL rnd_ready[%0d] got exu=%b lsu=%b want %b/1", n, exu_ready, lsu_ready, !lsu_valid);
      end
      tests++; if (iss_ready !== m_iss_ready()) begin
        fails++; $display("FAIL rnd_iss_ready[%0d] rd=%0d got %b want %b", n, iss_rd, iss_ready, m_iss_ready());
      end
      tests++; if (rs1_busy !== m_src_busy(rs1) || rs2_busy !== m_src_busy(rs2)) begin
        fails++; $display("FAIL rnd_rs_busy[%0d] got %b%b want %b%b", n, rs1_busy, rs2_busy, m_src_busy(rs1), m_src_busy(rs2));
      end
`ifdef WB_BYPASS_EN
      tests++; if (rs1_byp !== (m_wen && m_waddr == rs1) || rs1_bdata !== ((m_wen && m_waddr == rs1) ? m_wdata : 0)) begin
        fails++; $display("FAIL rnd_byp1[%0d] got %b/%h", n, rs1_byp, rs1_bdata);
      end
`endif
      tick();
      tests++; if (rf_wen !== m_wen || (m_wen && (rf_waddr !== AW'(m_waddr) || rf_wdata !== m_wdata))) begin
        fails++; $display("FAIL rnd_write[%0d] got wen=%b addr=%0d data=%h want %b/%0d/%h", n, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_issue_write();
    test_priority();
    test_waw();
    test_rd0();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
